// File: rtl/div_unit.sv
// div_unit: iterative 32-bit radix-2 restoring divide/remainder unit.
// Dividend comes from register file dout0 (a), divisor from dout1 (b).
// One quotient bit per cycle; start/busy/done handshake toward issue.
//
// Optional feature macro: DIV_FAST_SPECIAL_EN
//   When defined, divide-by-zero and signed overflow are resolved at accept
//   time and complete in one cycle without asserting busy.
//
// State table:
//   S_IDLE | waiting for start
//   S_CALC | one restoring iteration per cycle, 32 iterations
//   S_FIX  | phase 0: sign correction, phase 1: special cases + result register
//   S_DONE | done pulse; start may be accepted here
//   S_SPEC | fast special-case path (only reachable with DIV_FAST_SPECIAL_EN)
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_FIX  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_SPEC = 3'd4;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  div;
  logic [XLEN:0]    rem;
  logic             op_rem;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;
  logic             ovf;
  logic             fix_ph;

  logic             accept;
  logic             is_div_zero;
  logic             is_ovf;
  logic             take_fast;
  logic [XLEN-1:0]  a_abs;
  logic [XLEN-1:0]  b_abs;
  logic [XLEN+1:0]  shifted;
  logic [XLEN+1:0]  trial;
  logic [XLEN-1:0]  quo_fix;
  logic [XLEN-1:0]  rem_fix;
  logic [XLEN-1:0]  q_final;
  logic [XLEN-1:0]  r_final;

  assign busy   = (state == S_CALC) || (state == S_FIX);
  assign done   = (state == S_DONE);
  assign accept = start && !busy && (state != S_SPEC);

  // Operand magnitudes and special-case detection at the accept boundary.
  // The negation of INT_MIN wraps to itself, which is the correct unsigned
  // magnitude, so no extra handling is needed there.
  always_comb begin
    a_abs       = a;
    b_abs       = b;
    is_div_zero = (b == '0);
    is_ovf      = op[1] && (a == INT_MIN) && (b == ALL_ONES);
    if (op[1] && a[XLEN-1]) a_abs = -a;
    if (op[1] && b[XLEN-1]) b_abs = -b;
  end

`ifdef DIV_FAST_SPECIAL_EN
  assign take_fast = is_div_zero || is_ovf;
`else
  assign take_fast = 1'b0;
`endif

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
  // The extra top bit of the subtraction is the borrow (negative result).
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {2'b00, div};
  end

  // Sign correction and special-case substitution for the FIX stage.
  always_comb begin
    quo_fix = q_neg ? -quo : quo;
    rem_fix = r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    q_final = quo;
    r_final = rem[XLEN-1:0];
    if (div_zero) begin
      q_final = ALL_ONES;
      r_final = rem[XLEN-1:0];
    end else if (ovf) begin
      q_final = INT_MIN;
      r_final = '0;
    end
  end

  // Control FSM: state, iteration counter and FIX phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      fix_ph <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state  <= take_fast ? S_SPEC : S_CALC;
            cnt    <= CNT_LOAD;
            fix_ph <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_LAST) state <= S_FIX;
        end
        S_FIX: begin
          fix_ph <= ~fix_ph;
          if (fix_ph) state <= S_DONE;
        end
        S_SPEC: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operand latch at accept, iteration, sign fix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo      <= '0;
      div      <= '0;
      rem      <= '0;
      op_rem   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_rem   <= op[0];
            q_neg    <= op[1] & (a[XLEN-1] ^ b[XLEN-1]);
            r_neg    <= op[1] & a[XLEN-1];
            div_zero <= is_div_zero;
            ovf      <= is_ovf;
            div      <= b_abs;
            if (take_fast) begin
              // Fast path preloads the final values; SPEC just selects.
              quo <= is_div_zero ? ALL_ONES : INT_MIN;
              rem <= is_div_zero ? {1'b0, a} : '0;
            end else begin
              quo <= a_abs;
              rem <= '0;
            end
          end
        end
        S_CALC: begin
          if (!trial[XLEN+1]) begin
            rem <= trial[XLEN:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= shifted[XLEN:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
        end
        S_FIX: begin
          if (!fix_ph) begin
            quo <= quo_fix;
            rem <= {1'b0, rem_fix};
          end
        end
        default: ;
      endcase
    end
  end

  // Result and destination index; both hold until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      rd_out <= '0;
    end else begin
      if (accept) rd_out <= rd_in;
      if (state == S_FIX && fix_ph) result <= op_rem ? r_final : q_final;
      if (state == S_SPEC) result <= op_rem ? rem[XLEN-1:0] : quo;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit with hand-computed expected values.
module tb_div_unit;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif
  localparam int LAT = 34;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic [1:0] opv, input logic [4:0] rdv);
    a     = av;
    b     = bv;
    op    = opv;
    rd_in = rdv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1234_5678;
    rd_in = 5'd0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [1:0] opv, input logic [4:0] rdv,
                       input logic [31:0] exp_res, input int exp_lat);
    int lat;
    start_op(av, bv, opv, rdv);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rdv});
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int ndone;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    rd_in = '0;
    #12;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd",     {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned quotient then remainder, back-to-back from the DONE cycle.
    do_op("udiv", 32'd100, 32'd7, 2'b00, 5'd3, 32'd14, LAT);
    do_op("urem", 32'd100, 32'd7, 2'b01, 5'd17, 32'd2, LAT);
    // Signed: -100 / 7 = -14 rem -2.
    do_op("sdiv", 32'hFFFF_FF9C, 32'd7, 2'b10, 5'd5, 32'hFFFF_FFF2, LAT);
    do_op("srem", 32'hFFFF_FF9C, 32'd7, 2'b11, 5'd6, 32'hFFFF_FFFE, LAT);
    // Signed, negative divisor: 100 / -7 = -14 rem 2.
    do_op("sdiv_nb", 32'd100, 32'hFFFF_FFF9, 2'b10, 5'd7, 32'hFFFF_FFF2, LAT);
    do_op("srem_nb", 32'd100, 32'hFFFF_FFF9, 2'b11, 5'd8, 32'd2, LAT);
    // Unsigned operand with top bit set: 0x80000000 / 3 = 0x2AAAAAAA rem 2.
    do_op("udiv_big", 32'h8000_0000, 32'd3, 2'b00, 5'd9, 32'h2AAA_AAAA, LAT);

    // Special cases.
    do_op("dz_q", 32'd5, 32'd0, 2'b00, 5'd10, 32'hFFFF_FFFF, SPEC_LAT);
    do_op("dz_r", 32'd5, 32'd0, 2'b01, 5'd11, 32'd5, SPEC_LAT);
    do_op("dz_sr", 32'hFFFF_FFF6, 32'd0, 2'b11, 5'd12, 32'hFFFF_FFF6, SPEC_LAT);
    do_op("ovf_q", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 5'd13, 32'h8000_0000, SPEC_LAT);
    do_op("ovf_r", 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 5'd14, 32'd0, SPEC_LAT);

    // start pulsed while busy must be ignored.
    start_op(32'd1000, 32'd3, 2'b00, 5'd21);
    lat   = -1;
    ndone = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 10) begin
        a     = 32'd50;
        b     = 32'd5;
        op    = 2'b01;
        rd_in = 5'd2;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n == 5) chk("ign_busy_mid", {31'd0, busy}, 32'd1);
      if (done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
    chk("ign_lat",   32'(lat), 32'd34);
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_res",   result, 32'd333);
    chk("ign_rd",    {27'd0, rd_out}, 32'd21);

    // Reset in the middle of CALC.
    start_op(32'd7, 32'd2, 2'b00, 5'd4);
    for (int n = 1; n <= 15; n++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   {31'd0, busy}, 32'd0);
    chk("mid_rst_done",   {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_rd",     {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'd0);
    do_op("post_rst", 32'hFFFF_FFFF, 32'd1, 2'b00, 5'd31, 32'hFFFF_FFFF, LAT);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divide/remainder unit in the execute stage. It consumes the two registered operand words from the register file read ports (`dout0` as dividend, `dout1` as divisor) together with the destination register index. It delivers a single 32-bit result and that index to writeback. It uses a radix-2 restoring algorithm, one quotient bit per cycle, with a start/busy/done handshake toward the issue logic.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `CNT_W`, default 6: width of the iteration counter.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a new operation. Sampled only when `busy`=0.
- `op` in 2: operation select.
  - bit0: 0 = quotient, 1 = remainder.
  - bit1: 0 = unsigned, 1 = signed.
- `a` in 32: dividend (register file `dout0`).
- `b` in 32: divisor (register file `dout1`).
- `rd_in` in 5: destination register index.
- `busy` out 1: an operation is in progress. New `start` requests are ignored while high.
- `done` out 1: one-cycle pulse; `result` and `rd_out` are valid.
- `result` out 32: quotient or remainder, as selected by `op`.
- `rd_out` out 5: `rd_in` captured at accept time. Connects to register file `waddr`.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE / DONE**, when `start`=1:
  - Latch `op` and `rd_in`.
  - Latch |a| and |b|: absolute values if signed, raw values if unsigned.
  - Latch quotient sign = a[31]^b[31] and remainder sign = a[31]. Both are 0 for unsigned ops.
  - Clear the 33-bit partial remainder and load count=32. Go to CALC.
- **IDLE / DONE**, when `start`=0: go to or stay in IDLE.
- **CALC**, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor from rem[32:0]. If the result is non-negative, keep it and set quo[0]=1; otherwise restore.
  - Decrement count. Move to FIX after the 32nd iteration.
- **FIX:**
  - Negate quo and rem where their latched sign bits are set.
  - Apply the special cases below.
  - Select the output by op[0], register it into `result`, and go to DONE.
- **DONE:** `done`=1 for this single cycle.
  - `result` and `rd_out` hold their values until the next accept, including through IDLE.
- **Divide by zero** (b=0): quotient = 32'hFFFF_FFFF, remainder = a, in both signed and unsigned modes.
- **Signed overflow** (a=32'h8000_0000, b=32'hFFFF_FFFF, signed): quotient = 32'h8000_0000, remainder = 0.
- All arithmetic is modulo 2^32. The negation of 32'h8000_0000 is itself, which is why the unsigned magnitude path handles it.
- **Reset mid-operation** abandons the operation with no `done` pulse. All outputs return to their reset values.

## Timing
- **Reset values:** `busy`=0, `done`=0, `result`=0, `rd_out`=0, state IDLE.
- **Accept edge:** E0, the rising edge where `start`=1 and `busy`=0. Inputs need only be stable at E0.
- **`busy`:** 1 from after E0 through the edge that enters DONE.
- **Latency:** the CALC edges are E1..E32 and FIX is at E33. `done`=1 in the cycle after E34, which makes the latency 34 cycles.
- **Back-to-back:** `start` during DONE is accepted (`busy`=0 in DONE). The new operation's `done` arrives 34 cycles later, so throughput is one operation per 34 cycles.
- **`start` while `busy`=1:** ignored with no side effects.
- **`done` and `busy`** are never high in the same cycle.

## Configuration
- `DIV_FAST_SPECIAL_EN`, when defined:
  - Divide-by-zero and signed overflow are detected at accept time.
  - CALC and FIX are skipped, and the state goes directly to DONE with the special result.
  - `done` is high in the cycle after E1, which makes the latency 1 cycle.
  - `busy` is never asserted for these operations.
- When undefined, the special cases take the full 34 cycles with identical result values.
- All other operations have identical timing either way.

## Test plan
- Unsigned divide, a=100, b=7, op=00: `done` exactly 34 cycles after accept, `result`=14. Repeating with op=01 gives `result`=2. `rd_out` equals the latched `rd_in`.
- Signed divide, a=-100 (32'hFFFF_FF9C), b=7:
  - op=10 gives `result`=32'hFFFF_FFF2 (-14).
  - op=11 gives `result`=32'hFFFF_FFFE (-2).
- Special cases:
  - b=0, a=5, op=00 gives 32'hFFFF_FFFF; op=01 gives 5.
  - a=32'h8000_0000, b=-1, op=10 gives 32'h8000_0000; op=11 gives 0.
  - Latency is 34 cycles without `DIV_FAST_SPECIAL_EN` and 1 cycle with it.
- Handshake:
  - `start` pulsed at cycle 10 of a busy operation: no effect on the result or the `done` count.
  - `start` held high in the DONE cycle: accepted, and a second `done` follows 34 cycles later with the correct result.
- Reset:
  - `rst_n` asserted at CALC iteration 15: `busy` and `done` are 0 immediately and no `done` appears.
  - After release, a fresh operation (a=32'hFFFF_FFFF, b=1, unsigned) returns 32'hFFFF_FFFF.
